machine_ctrl: RTL

MACHINE_CTRL -- requirements
Module: machine_ctrl

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 40 ++++
 rtl/machine_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg -- shared definitions for the simple CPU control slice.
//   * opcode encodings of the instruction register opcode field
//   * width of the per-instruction step counter and its state encoding
//   * packed bundle of the eight datapath control strobes
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    // Eight steps per instruction; the counter wraps from ST_7 to ST_0.
    typedef enum logic [STEP_W-1:0] {
        ST_0 = 3'd0,
        ST_1 = 3'd1,
        ST_2 = 3'd2,
        ST_3 = 3'd3,
        ST_4 = 3'd4,
        ST_5 = 3'd5,
        ST_6 = 3'd6,
        ST_7 = 3'd7
    } step_e;

    // Bit order (MSB first) matches the way the strobes are usually listed
    // on a waveform: halt at the top, inc_pc at the bottom.
    typedef struct packed {
        logic halt;
        logic datactl_ena;
        logic load_ir;
        logic wr;
        logic rd;
        logic load_pc;
        logic load_acc;
        logic inc_pc;
    } ctl_t;

    localparam ctl_t CTL_NONE = ctl_t'(8'h00);
    localparam ctl_t CTL_HALT = ctl_t'(8'h80);

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode -- combinational opcode classification.
// Ports:
//   opcode     in  3  opcode field of the instruction register
//   is_alu_ld  out 1  ADD / AND / XOR / LDA (operand read into accumulator)
//   is_sto     out 1  STO
//   is_jmp     out 1  JMP
//   is_skz     out 1  SKZ
//   is_hlt     out 1  HLT
// ---------------------------------------------------------------------------
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0] opcode,
    output logic       is_alu_ld,
    output logic       is_sto,
    output logic       is_jmp,
    output logic       is_skz,
    output logic       is_hlt
);

    // One-hot classification of the opcode into the groups the sequencer uses.
    always_comb begin
        is_alu_ld = 1'b0;
        is_sto    = 1'b0;
        is_jmp    = 1'b0;
        is_skz    = 1'b0;
        is_hlt    = 1'b0;
        case (opcode_e'(opcode))
            OP_HLT:                      is_hlt    = 1'b1;
            OP_SKZ:                      is_skz    = 1'b1;
            OP_ADD, OP_AND, OP_XOR,
            OP_LDA:                      is_alu_ld = 1'b1;
            OP_STO:                      is_sto    = 1'b1;
            OP_JMP:                      is_jmp    = 1'b1;
            default:                     is_hlt    = 1'b0;
        endcase
    end

endmodule

// File: rtl/machine_ctrl.sv
// ---------------------------------------------------------------------------
// machine_ctrl -- eight-step instruction sequencer for the simple CPU.
// Once fetch is first seen high the controller runs forever (until reset),
// stepping 0..7 per instruction and issuing registered datapath strobes.
// An HLT opcode at step 3 halts the sequencer until reset.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   fetch        in   1      fetch window; first sampled 1 starts the sequencer
//   opcode       in   3      opcode field of the instruction register
//   zero         in   1      accumulator-is-zero flag
//   inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt
//                out  1 ea.  registered datapath controls
//   instr_cnt    out  CNT_W  retired-instruction count
//                            (only when CTRL_INSTR_CNT_EN is defined)
//
// Configuration macro: CTRL_INSTR_CNT_EN -- adds the retired-instruction
// counter and its output port. Undefined by default.
// ---------------------------------------------------------------------------
module machine_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             inc_pc,
    output logic             load_acc,
    output logic             load_pc,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             datactl_ena,
`ifdef CTRL_INSTR_CNT_EN
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
`else
    output logic             halt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("machine_ctrl: CNT_W must be at least 1");
    end

    logic  run_r;
    logic  halted_r;
    step_e step_r;
    ctl_t  ctl_r;
    ctl_t  ctl_nxt_s;

    logic  is_alu_ld_s;
    logic  is_sto_s;
    logic  is_jmp_s;
    logic  is_skz_s;
    logic  is_hlt_s;
    logic  skip_s;

    ctrl_decode u_decode (
        .opcode    (opcode),
        .is_alu_ld (is_alu_ld_s),
        .is_sto    (is_sto_s),
        .is_jmp    (is_jmp_s),
        .is_skz    (is_skz_s),
        .is_hlt    (is_hlt_s)
    );

    // SKZ skips the next word only when the accumulator is zero.
    assign skip_s = is_skz_s & zero;

    // Strobes for the current step. opcode/zero feed only the steps that
    // use them, so their values on other steps cannot leak into outputs.
    always_comb begin
        ctl_nxt_s = CTL_NONE;
        case (step_r)
            ST_0: begin
                ctl_nxt_s.rd      = 1'b1;
                ctl_nxt_s.load_ir = 1'b1;
            end
            ST_1: begin
                ctl_nxt_s.rd      = 1'b1;
                ctl_nxt_s.load_ir = 1'b1;
                ctl_nxt_s.inc_pc  = 1'b1;
            end
            ST_2: begin
                ctl_nxt_s = CTL_NONE;
            end
            ST_3: begin
                ctl_nxt_s.inc_pc = 1'b1;
                ctl_nxt_s.halt   = is_hlt_s;
            end
            ST_4: begin
                ctl_nxt_s.load_pc     = is_jmp_s;
                ctl_nxt_s.rd          = is_alu_ld_s;
                ctl_nxt_s.datactl_ena = is_sto_s;
            end
            ST_5: begin
                ctl_nxt_s.rd          = is_alu_ld_s;
                ctl_nxt_s.load_acc    = is_alu_ld_s;
                ctl_nxt_s.inc_pc      = skip_s | is_jmp_s;
                ctl_nxt_s.load_pc     = is_jmp_s;
                ctl_nxt_s.wr          = is_sto_s;
                ctl_nxt_s.datactl_ena = is_sto_s;
            end
            ST_6: begin
                ctl_nxt_s.datactl_ena = is_sto_s;
                ctl_nxt_s.rd          = is_alu_ld_s;
            end
            ST_7: begin
                ctl_nxt_s.inc_pc = skip_s;
            end
            default: begin
                ctl_nxt_s = CTL_NONE;
            end
        endcase
    end

    // Sequencer state: run/halted flags, step counter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r    <= 1'b0;
            halted_r <= 1'b0;
            step_r   <= ST_0;
            ctl_r    <= CTL_NONE;
        end else if (!run_r) begin
            // Idle: wait for the first fetch window; run is sticky after that.
            run_r  <= fetch;
            step_r <= ST_0;
            ctl_r  <= CTL_NONE;
        end else if (halted_r) begin
            // Halted: step frozen, only halt stays asserted.
            ctl_r <= CTL_HALT;
        end else begin
            step_r   <= step_e'(step_r + 3'd1);
            ctl_r    <= ctl_nxt_s;
            halted_r <= (step_r == ST_3) && is_hlt_s;
        end
    end

`ifdef CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt_r;

    // Count an instruction each time the step counter wraps 7 -> 0.
    // HLT freezes the counter at step 4, so it is never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if (run_r && !halted_r && (step_r == ST_7)) begin
            instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_cnt = instr_cnt_r;
`endif

    assign inc_pc      = ctl_r.inc_pc;
    assign load_acc    = ctl_r.load_acc;
    assign load_pc     = ctl_r.load_pc;
    assign rd          = ctl_r.rd;
    assign wr          = ctl_r.wr;
    assign load_ir     = ctl_r.load_ir;
    assign datactl_ena = ctl_r.datactl_ena;
    assign halt        = ctl_r.halt;

endmodule
